// File: rtl/mac_pipe_acc.sv
`default_nettype none
// ============================================================================
// mac_pipe_acc : signed 16x16 multiply-accumulate, 32-bit accumulator,
//                two-stage pipeline (registered product, registered acc).
// Optional feature macro: MAC_SATURATE_EN (clamp MAC overflow instead of wrap)
// Revision: 1.0
// ============================================================================
module mac_pipe_acc (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [15:0] X,
   input  logic [15:0] Y,
   input  logic        acc_load,
   input  logic [31:0] Z,
   output logic [31:0] Result
);

   typedef enum logic [1:0] {
      OP_NOP  = 2'd0,
      OP_LOAD = 2'd1,
      OP_MAC  = 2'd2
   } op_e;

   op_e                op_d, op_q;
   logic signed [31:0] x_ext, y_ext;
   logic signed [31:0] prod_d, prod_q;
   logic        [31:0] z_d, z_q;
   logic        [31:0] acc_d, acc_q;

`ifdef MAC_SATURATE_EN
   // Bits 32 and 31 of the sign-extended sum disagree exactly on overflow.
   logic [32:0] sum_w;
   assign sum_w = {acc_q[31], acc_q} + {prod_q[31], prod_q};
`else
   logic [31:0] sum_w;
   assign sum_w = acc_q + prod_q;
`endif

   // Stage 1: op decode (LOAD wins over MAC) and exact signed product.
   always_comb begin
      op_d = OP_NOP;
      if (en) begin
         op_d = acc_load ? OP_LOAD : OP_MAC;
      end
      x_ext  = {{16{X[15]}}, X};
      y_ext  = {{16{Y[15]}}, Y};
      prod_d = x_ext * y_ext;
      z_d    = Z;
   end

   // Stage 2: accumulate.
   always_comb begin
      acc_d = acc_q;
      case (op_q)
         OP_LOAD: acc_d = z_q;
         OP_MAC: begin
`ifdef MAC_SATURATE_EN
            if (sum_w[32] != sum_w[31]) begin
               acc_d = sum_w[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end else begin
               acc_d = sum_w[31:0];
            end
`else
            acc_d = sum_w;
`endif
         end
         default: acc_d = acc_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q   <= OP_NOP;
         prod_q <= '0;
         z_q    <= '0;
         acc_q  <= '0;
      end else begin
         op_q   <= op_d;
         prod_q <= prod_d;
         z_q    <= z_d;
         acc_q  <= acc_d;
      end
   end

   assign Result = acc_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_pipe_acc.sv
`default_nettype none
`timescale 1ns/1ps
// tb_mac_pipe_acc : scoreboard bench; each issued op pushes its expected
// accumulator value, popped one cycle later when the DUT reflects it.
module tb_mac_pipe_acc;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        acc_load;
   logic [15:0] X;
   logic [15:0] Y;
   logic [31:0] Z;
   logic [31:0] Result;

   always #5 clk = ~clk;

   mac_pipe_acc dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .X       (X),
      .Y       (Y),
      .acc_load(acc_load),
      .Z       (Z),
      .Result  (Result)
   );

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } exp_t;

   exp_t        sb_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] model_acc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mac_model(input logic [31:0] acc,
                                             input logic [15:0] x,
                                             input logic [15:0] y);
      longint s;
      s = longint'($signed(acc)) + longint'($signed(x)) * longint'($signed(y));
`ifdef MAC_SATURATE_EN
      if (s > 64'sd2147483647)  return 32'h7FFF_FFFF;
      if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
      return s[31:0];
   endfunction

   // Drive one op, step one edge, compare the op issued one edge earlier.
   task automatic step(input string tag, input logic e, input logic ld,
                       input logic [15:0] x, input logic [15:0] y, input logic [31:0] z);
      exp_t item;
      en = e; acc_load = ld; X = x; Y = y; Z = z;
      if (e && ld)  model_acc = z;
      else if (e)   model_acc = mac_model(model_acc, x, y);
      item.tag = tag;
      item.exp = model_acc;
      sb_q.push_back(item);
      @(posedge clk); #1;
      if (sb_q.size() >= 2) begin
         item = sb_q.pop_front();
         check(item.tag, Result, item.exp);
      end
   endtask

   task automatic nop(input string tag);
      step(tag, 1'b0, 1'b0, 16'($urandom), 16'($urandom), $urandom);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      model_acc = '0;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         en = 1'b1; acc_load = i[0];
         X = 16'($urandom); Y = 16'($urandom); Z = $urandom;
         @(posedge clk); #1;
         check("reset_hold", Result, 32'h0);
      end
      en = 1'b0;
      rst = 1'b1;
      nop("idle0");
      nop("idle1");
      nop("idle2");

      step("load50",   1'b1, 1'b1, 16'h7FFF, 16'h7FFF, 32'd50);
      step("mac10x3",  1'b1, 1'b0, 16'd10, 16'd3, 32'hDEAD_BEEF);
      nop("hold80a");
      nop("hold80b");

      step("load20",   1'b1, 1'b1, 16'd1, 16'd1, 32'd20);
      step("mac-5x4",  1'b1, 1'b0, -16'sd5, 16'd4, 32'd0);
      step("load0",    1'b1, 1'b1, 16'd9, 16'd9, 32'd0);
      step("mac7x-6",  1'b1, 1'b0, 16'd7, -16'sd6, 32'd0);
      nop("hold-42");

      step("load0b",   1'b1, 1'b1, 16'd0, 16'd0, 32'd0);
      for (int i = 0; i < 4; i++) step("cont3x4", 1'b1, 1'b0, 16'd3, 16'd4, 32'd0);
      nop("cont_hold");

      step("load_max", 1'b1, 1'b1, 16'd0, 16'd0, 32'h7FFF_FFF0);
      step("mac_pos_ovf", 1'b1, 1'b0, 16'h8000, 16'h8000, 32'd0);
      nop("pos_ovf_hold");
      step("load_min", 1'b1, 1'b1, 16'd0, 16'd0, 32'h8000_0010);
      step("mac_neg_ovf", 1'b1, 1'b0, 16'h8000, 16'h7FFF, 32'd0);
      nop("neg_ovf_hold");

      for (int i = 0; i < 40; i++) begin
         step("random", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
              16'($urandom), 16'($urandom), $urandom);
      end

      // Build a nonzero accumulator, then reset between edges with a MAC in flight.
      step("pre_rst_load", 1'b1, 1'b1, 16'd0, 16'd0, 32'd1000);
      step("pre_rst_mac",  1'b1, 1'b0, 16'd100, 16'd100, 32'd0);
      step("pre_rst_mac2", 1'b1, 1'b0, 16'd100, 16'd100, 32'd0);
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_immediate", Result, 32'h0);
      sb_q.delete();
      model_acc = '0;
      en = 1'b0;
      @(posedge clk); #3;
      rst = 1'b1;
      @(posedge clk); #1;
      check("post_rst_no_inflight", Result, 32'h0);
      nop("post_rst0");
      nop("post_rst1");
      step("post_rst_mac", 1'b1, 1'b0, -16'sd2, 16'd21, 32'd0);
      nop("post_rst_mac_res");
      nop("drain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
